// File: rtl/fir_mac_core_param.sv
// Streaming N-tap multi-channel FIR MAC with shadow coefficient load/commit,
// output shift, saturation and sticky protocol error. Optional: FIR_ROUND_EN.
module fir_mac_core_param #(
    parameter int CH    = 3,
    parameter int DW    = 8,
    parameter int CW    = 8,
    parameter int TAPS  = 9,
    parameter int SHIFT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CH*DW-1:0]   in_data,
    input  logic               in_valid,
    input  logic               in_tc_set,
    output logic               in_ready,
    output logic [CH*DW-1:0]   out_data,
    output logic               out_valid,
    output logic               err,
    output logic [1:0]         dbg_state
);

    localparam int ACC_W = DW + CW + $clog2(TAPS) + 1;
    localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int PW    = CW + DW + 1;

    // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
    // in_ready drops only during the single OUT cycle.
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_OUT} state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic signed [CW-1:0]    coef_act [TAPS][CH];
    logic signed [CW-1:0]    coef_shd [TAPS][CH];
    logic signed [ACC_W-1:0] acc      [CH];
    logic signed [ACC_W-1:0] acc_nxt  [CH];
    logic signed [PW-1:0]    prod     [CH];
    logic signed [ACC_W:0]   rnd      [CH];
    logic signed [ACC_W:0]   shr      [CH];
    logic [CH*DW-1:0]        res;
    logic accept, last, do_load, do_mac, abort, stray;

    assign in_ready  = (state != S_OUT);
    assign dbg_state = state;
    assign accept    = in_valid && in_ready;
    assign last      = (cnt == CNT_W'(TAPS - 1));
    assign do_load   = accept && in_tc_set && (state == S_IDLE || state == S_LOAD);
    assign do_mac    = accept && !in_tc_set && (state == S_IDLE || state == S_CALC);
    assign abort     = accept && !in_tc_set && (state == S_LOAD);
    assign stray     = accept && in_tc_set && (state == S_CALC);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (accept) state_nxt = in_tc_set ? (last ? S_IDLE : S_LOAD)
                                                      : (last ? S_OUT  : S_CALC);
            S_LOAD: if (accept && (!in_tc_set || last)) state_nxt = S_IDLE;
            S_CALC: if (accept && !in_tc_set && last) state_nxt = S_OUT;
            S_OUT:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef FIR_ROUND_EN
    localparam logic signed [ACC_W:0] RND =
        (SHIFT > 0) ? ((ACC_W+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`endif

    // Pixels are zero-extended so the multiply stays signed x signed.
    always_comb begin
        res = '0;
        for (int k = 0; k < CH; k++) begin
            prod[k]    = PW'(coef_act[cnt][k]) * PW'($signed({1'b0, in_data[k*DW +: DW]}));
            acc_nxt[k] = acc[k] + ACC_W'(prod[k]);
`ifdef FIR_ROUND_EN
            rnd[k] = $signed({acc[k][ACC_W-1], acc[k]}) + RND;
`else
            rnd[k] = $signed({acc[k][ACC_W-1], acc[k]});
`endif
            shr[k] = rnd[k] >>> SHIFT;
            if (shr[k][ACC_W])              res[k*DW +: DW] = '0;
            else if (|shr[k][ACC_W-1:DW])   res[k*DW +: DW] = '1;
            else                            res[k*DW +: DW] = shr[k][DW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            for (int k = 0; k < CH; k++) acc[k] <= '0;
            for (int t = 0; t < TAPS; t++)
                for (int k = 0; k < CH; k++) begin
                    coef_act[t][k] <= '0;
                    coef_shd[t][k] <= '0;
                end
        end else begin
            out_valid <= 1'b0;
            if (abort || stray) err <= 1'b1;
            if (abort) cnt <= '0;
            if (do_load) begin
                for (int k = 0; k < CH; k++) coef_shd[cnt][k] <= in_data[k*CW +: CW];
                if (last) begin
                    cnt <= '0;
                    // Commit includes the word arriving on this same edge.
                    for (int t = 0; t < TAPS; t++)
                        for (int k = 0; k < CH; k++)
                            coef_act[t][k] <= (t == int'(cnt)) ? in_data[k*CW +: CW]
                                                               : coef_shd[t][k];
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
            if (do_mac) begin
                for (int k = 0; k < CH; k++) acc[k] <= acc_nxt[k];
                cnt <= last ? '0 : cnt + CNT_W'(1);
            end
            if (state == S_OUT) begin
                out_data  <= res;
                out_valid <= 1'b1;
                cnt       <= '0;
                for (int k = 0; k < CH; k++) acc[k] <= '0;
            end
        end
    end

endmodule
